// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
// alu_cmd_sequencer
// -----------------------------------------------------------------------------
// Issue stage in front of the 4-bit combinational ALU. Commands {a, b, op}
// are buffered in a DEPTH-entry FIFO and issued one at a time through
// registered alu_* outputs. The ALU result and zero flag are captured one
// cycle after issue into a response register with a valid/ready handshake.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_a, cmd_b, cmd_op payload
//   alu_operandA/B, alu_operation  registered drive into the ALU
//   alu_result, alu_zero      combinational ALU outputs fed back
//   rsp_valid/rsp_ready       response handshake; rsp_result, rsp_zero, rsp_op
//   fifo_count                current FIFO occupancy
//   busy                      FSM not idle or FIFO not empty
//   illegal_op                (only with ALU_ILLEGAL_OP_TRAP_EN) sticky flag,
//                             set when an opcode 101/110/111 is dropped at pop
//
// Build option: define ALU_ILLEGAL_OP_TRAP_EN to drop illegal opcodes at pop
// instead of issuing them to the ALU.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [3:0]       alu_operandA,
  output logic [3:0]       alu_operandB,
  output logic [2:0]       alu_operation,
  input  logic [7:0]       alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_zero,
  output logic [2:0]       rsp_op,
  output logic [CNT_W-1:0] fifo_count,
  output logic             busy
`ifdef ALU_ILLEGAL_OP_TRAP_EN
  ,
  output logic             illegal_op
`endif
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // FIFO entry layout: [10:7] operand A, [6:3] operand B, [2:0] opcode
  logic [10:0]      fifo_mem_q [DEPTH];
  logic [10:0]      fifo_mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  state_e           state_q, state_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic             busy_q, busy_d;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
  logic             illegal_q, illegal_d;
`endif

  logic             push_s;
  logic             pop_s;
  logic [10:0]      head_s;
  logic             head_legal_s;

  // cmd_ready is forced low during reset so nothing is accepted while flushing
  assign cmd_ready = (count_q < DEPTH_C) && !rst;
  assign push_s    = cmd_valid && cmd_ready;
  assign head_s    = fifo_mem_q[rd_ptr_q];

`ifdef ALU_ILLEGAL_OP_TRAP_EN
  assign head_legal_s = (head_s[2:0] <= 3'd4);
  assign illegal_op   = illegal_q;
`else
  assign head_legal_s = 1'b1;
`endif

  assign alu_operandA  = alu_a_q;
  assign alu_operandB  = alu_b_q;
  assign alu_operation = alu_op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_op        = rsp_op_q;
  assign fifo_count    = count_q;
  assign busy          = busy_q;

  // Sequencer next-state: issue, capture and response handshake
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_op_d     = rsp_op_q;
    pop_s        = 1'b0;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
    illegal_d    = illegal_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (count_q != CNT_ZERO) begin
          pop_s = 1'b1;
          if (head_legal_s) begin
            alu_a_d  = head_s[10:7];
            alu_b_d  = head_s[6:3];
            alu_op_d = head_s[2:0];
            state_d  = ST_ISSUE;
          end else begin
            // dropped command: alu_* registers keep their previous value
            state_d = ST_IDLE;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
            illegal_d = 1'b1;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // ALU has had one full cycle to settle on the registered operands
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_op_d     = alu_op_q;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          // count_q excludes a same-edge push, so a push into an empty FIFO
          // here is picked up from IDLE on the following cycle
          if (count_q != CNT_ZERO) begin
            pop_s = 1'b1;
            if (head_legal_s) begin
              alu_a_d  = head_s[10:7];
              alu_b_d  = head_s[6:3];
              alu_op_d = head_s[2:0];
              state_d  = ST_ISSUE;
            end else begin
              state_d = ST_IDLE;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
              illegal_d = 1'b1;
`endif
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO storage, pointers, occupancy and busy next-state
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = {cmd_a, cmd_b, cmd_op};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    busy_d = (state_d != ST_IDLE) || (count_d != CNT_ZERO);
  end

  // State registers with asynchronous flush of FIFO, in-flight command and response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_q[i] <= 11'd0;
      end
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= CNT_ZERO;
      state_q      <= ST_IDLE;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      alu_op_q     <= 3'd0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 8'd0;
      rsp_zero_q   <= 1'b0;
      rsp_op_q     <= 3'd0;
      busy_q       <= 1'b0;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      fifo_mem_q   <= fifo_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_op_q     <= rsp_op_d;
      busy_q       <= busy_d;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
      illegal_q    <= illegal_d;
`endif
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the 4-bit ALU. It buffers operand/opcode commands in a small FIFO and drives the ALU's operandA/operandB/operation from registers, one command at a time. It captures the ALU's combinational result and zeroFlag one cycle later into a response register with a valid/ready handshake. This turns the purely combinational ALU into a flow-controlled, pipelined datapath stage.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, >= 2.
CNT_W, 3, fifo_count width; must equal log2(DEPTH)+1.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept a command
cmd_a  in  4  operand A
cmd_b  in  4  operand B
cmd_op  in  3  opcode: 000 add, 001 sub, 010 AND, 011 OR, 100 mul
alu_operandA  out  4  registered, to ALU operandA
alu_operandB  out  4  registered, to ALU operandB
alu_operation  out  3  registered, to ALU operation
alu_result  in  8  ALU result, combinational from the alu_* outputs
alu_zero  in  1  ALU zeroFlag
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts the response
rsp_result  out  8  captured result
rsp_zero  out  1  captured zeroFlag
rsp_op  out  3  opcode that produced the response
fifo_count  out  CNT_W  current FIFO occupancy
busy  out  1  FSM not IDLE or fifo_count != 0

Behaviour:
- Reset, asynchronous:
  - All outputs 0, FIFO empty, FSM in IDLE.
  - cmd_ready is gated low while rst=1.
  - Reset mid-operation discards the FIFO contents, the in-flight command and any pending response. Nothing is emitted afterwards.
- Push: when cmd_valid && cmd_ready, {cmd_a, cmd_b, cmd_op} is written at the tail.
- cmd_ready = (fifo_count < DEPTH) && !rst. There is no push-through when full.
- Pop and push in the same cycle leave fifo_count unchanged. The pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if fifo_count > 0, pop the head into the alu_* registers and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: lasts exactly 1 cycle while the ALU settles. At the exiting edge, capture alu_result into rsp_result, alu_zero into rsp_zero and alu_operation into rsp_op; set rsp_valid=1; go to RESP.
  - RESP: rsp_valid is held and rsp_result/rsp_zero/rsp_op stay stable until rsp_valid && rsp_ready.
    - On that handshake edge, if fifo_count > 0 (evaluated before any same-edge push), pop the next command into the alu_* registers, clear rsp_valid and go to ISSUE.
    - Otherwise clear rsp_valid and go to IDLE.
- The alu_* registers hold their last value between commands.
- Latency: a command accepted at edge E0 into an empty, idle block pops at E1, is captured at E2, and rsp_valid is high after E2.
- Throughput: at most 1 response per 2 cycles when rsp_ready is held high.
- A push to an empty FIFO on the RESP handshake edge is not popped on that edge. It pops on the next IDLE cycle.
- Width rules: the sequencer never alters data. Operands, opcode, result and zero flag pass through unchanged.
- rsp_ready high while rsp_valid is low has no effect.

Optional Feature:
Macro ALU_ILLEGAL_OP_TRAP_EN.
- Defined:
  - Opcodes 101, 110 and 111 are accepted into the FIFO but are dropped at pop. The FSM stays in or returns to IDLE with no response, and the alu_* registers are not updated.
  - An extra output port, illegal_op (1 bit), is added. It is sticky, set on the drop, and cleared only by rst.
- Undefined: every opcode is issued to the ALU unchanged, and the illegal_op port does not exist.

Test Plan:
- Reset then a single command, a=13, b=10, op=000, rsp_ready=1: rsp_valid rises 2 edges after acceptance with rsp_result=0x17, rsp_zero=0, rsp_op=000.
- Back-to-back a=13, b=10 with ops 001, 010, 011, 100 and rsp_ready=1: in-order responses 0x03, 0x08, 0x0F, 0x82, spaced 2 cycles apart.
- a=5, b=5, op=001: rsp_result=0x00 and rsp_zero=1.
- rsp_ready=0, offer 6 commands: 5 are accepted (1 held in RESP, 4 in FIFO). fifo_count=4, cmd_ready=0, and the 6th is held. Releasing rsp_ready drains all 6 in order, with the 6th accepted once a slot frees.
- Assert rst while in ISSUE with 3 commands queued: all outputs go to 0 immediately, fifo_count=0, and no response appears after release.
- With ALU_ILLEGAL_OP_TRAP_EN, send op=110 followed by a=2, b=3, op=000: illegal_op=1, the only response is 0x05, and alu_operation never shows 110.
